// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: iterative shift-and-add unsigned multiplier.
// Accepts one operand pair at a time and returns the WL-bit product a fixed
// WS cycles after the accept edge, then holds it until the consumer takes it.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand pair offered
//   in_ready   out  1   operands accepted (high only in IDLE)
//   in_a       in   WS  multiplicand, unsigned
//   in_b       in   WS  multiplier, unsigned
//   out_valid  out  1   product available (DONE)
//   out_ready  in   1   consumer takes product
//   out_p      out  WL  product register (holds last product in IDLE)
//   busy       out  1   high in RUN or DONE
module seq_shift_add_mul #(
  parameter int unsigned WS = 16,
  parameter int unsigned WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WS-1:0] in_a,
  input  logic [WS-1:0] in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] out_p,
  output logic          busy
);

  localparam int unsigned CW = $clog2(WS) + 1;

  // The product must be exactly twice the operand width.
  if (WL != 2 * WS) begin : g_width_check
    $error("seq_shift_add_mul: WL must equal 2*WS");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [WL-1:0] acc;
  logic [WL-1:0] mcand;
  logic [WS-1:0] mplier;
  logic [WS-1:0] a_q;
  logic [WS-1:0] b_q;
  logic [CW-1:0] cnt;
  logic          last_step;

  assign last_step = (cnt == CW'(WS - 1));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last_step) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state so
  // they always track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Datapath: load on accept, one shift-and-add step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand  <= WL'(in_a);
            mplier <= in_b;
            acc    <= '0;
            cnt    <= '0;
            a_q    <= in_a;
            b_q    <= in_b;
          end
        end
        S_RUN: begin
          // Fixed WS steps; the partial sum never exceeds WL bits.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_p = acc;

  // Embedded properties.
  a_product: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> (out_p == (WL'(a_q) * WL'(b_q))));
  a_ready_idle: assert property (@(posedge clk) disable iff (rst)
    in_ready == (state == S_IDLE));
  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

endmodule
